// File: rtl/parking_gate_ctrl_p_if.sv
// Sensor / keypad / barrier bundle for the parking gate controller.
// master drives the field inputs, slave is the controller side.
interface parking_gate_ctrl_p_if #(
  parameter int PIN_WIDTH = 8,
  parameter int CNT_W     = 8
);
  logic                 sensor_a;
  logic                 sensor_b;
  logic                 pin_validation;
  logic [PIN_WIDTH-1:0] pin;
  logic                 salida;
  logic                 alarma_pin_incorrecto;
  logic                 alarma_bloqueo;
  logic                 senal_abrir_compuerta;
  logic                 senal_cerrar_compuerta;
  logic                 lleno;
  logic [CNT_W-1:0]     vehiculos;

  modport master (
    output sensor_a, sensor_b, pin_validation,
    output pin, salida,
    input  alarma_pin_incorrecto, alarma_bloqueo,
    input  senal_abrir_compuerta, senal_cerrar_compuerta,
    input  lleno, vehiculos
  );

  modport slave (
    input  sensor_a, sensor_b, pin_validation,
    input  pin, salida,
    output alarma_pin_incorrecto, alarma_bloqueo,
    output senal_abrir_compuerta, senal_cerrar_compuerta,
    output lleno, vehiculos
  );
endinterface

// File: rtl/parking_gate_ctrl_p.sv
// Parking gate controller: PIN check with retries, open timeout,
// occupancy count with full flag and a dual-sensor blocking state.
module parking_gate_ctrl_p #(
  parameter int                 PIN_WIDTH    = 8,
  parameter logic [PIN_WIDTH-1:0] PIN_CODE   = 8'b00111101,
  parameter int                 MAX_TRIES    = 3,
  parameter int                 OPEN_TIMEOUT = 32,
  parameter int                 CAPACITY     = 100,
  parameter int                 CNT_W        = 8
) (
  input logic                   clock,
  input logic                   reset,
  parking_gate_ctrl_p_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_PIN  = 3'd1,
    OPEN      = 3'd2,
    PIN_ALARM = 3'd3,
    CLOSING   = 3'd4,
    BLOCKED   = 3'd5
  } state_t;

  localparam logic [3:0]       MAX_T   = 4'(MAX_TRIES);
  localparam logic [15:0]      TO_LAST = 16'(OPEN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CAP     = CNT_W'(CAPACITY);

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  logic [3:0]       fails_q, fails_d;
  logic [15:0]      timer_q, timer_d;
  logic             pin_al_q, pin_al_d;
  logic             blk_q, blk_d;
  logic             abrir_q, abrir_d;
  logic             cerrar_q, cerrar_d;
  logic             lleno_q, lleno_d;
  logic [CNT_W-1:0] veh_q, veh_d;

  logic a, b, ok_pin, bad_pin, both, pass;

  assign a       = bus.sensor_a;
  assign b       = bus.sensor_b;
  assign both    = a & b;
  assign ok_pin  = bus.pin_validation & (bus.pin == PIN_CODE);
  assign bad_pin = bus.pin_validation & (bus.pin != PIN_CODE);

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    fails_d = fails_q;
    timer_d = timer_q;
    pass    = 1'b0;
    if (state_q != BLOCKED && both) begin
      ret_d   = state_q;
      state_d = BLOCKED;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (a & ~b & ~lleno_q) begin
            state_d = WAIT_PIN;
            fails_d = '0;
          end
        end
        WAIT_PIN: begin
          if (ok_pin) begin
            state_d = OPEN;
            fails_d = '0;
            timer_d = '0;
          end else if (bad_pin) begin
            fails_d = fails_q + 4'd1;
            if (fails_q + 4'd1 == MAX_T)
              state_d = PIN_ALARM;
          end else if (~a & ~b) begin
            state_d = IDLE;
          end
        end
        PIN_ALARM: begin
          if (ok_pin) begin
            state_d = OPEN;
            fails_d = '0;
            timer_d = '0;
          end
        end
        OPEN: begin
          timer_d = timer_q + 16'd1;
          if (b & ~a) begin
            state_d = CLOSING;
            pass    = 1'b1;
          end else if (timer_q == TO_LAST) begin
            state_d = CLOSING;
          end
        end
        CLOSING: begin
          if (~b)
            state_d = IDLE;
        end
        BLOCKED: begin
          if (ok_pin) begin
            state_d = ret_q;
            if (ret_q == OPEN)
              timer_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Registered outputs follow the state being entered on this edge.
  always_comb begin
    abrir_d  = (state_d == OPEN);
    cerrar_d = (state_d == CLOSING);
    blk_d    = (state_d == BLOCKED);
    pin_al_d = (state_d == PIN_ALARM)
             | ((state_d == BLOCKED) & pin_al_q);
  end

  always_comb begin
    veh_d = veh_q;
    if (pass & ~bus.salida) begin
      if (veh_q < CAP)
        veh_d = veh_q + 1'b1;
    end else if (bus.salida & ~pass) begin
      if (veh_q != '0)
        veh_d = veh_q - 1'b1;
    end
    lleno_d = (veh_d == CAP);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      ret_q    <= IDLE;
      fails_q  <= '0;
      timer_q  <= '0;
      pin_al_q <= 1'b0;
      blk_q    <= 1'b0;
      abrir_q  <= 1'b0;
      cerrar_q <= 1'b0;
      lleno_q  <= 1'b0;
      veh_q    <= '0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      fails_q  <= fails_d;
      timer_q  <= timer_d;
      pin_al_q <= pin_al_d;
      blk_q    <= blk_d;
      abrir_q  <= abrir_d;
      cerrar_q <= cerrar_d;
      lleno_q  <= lleno_d;
      veh_q    <= veh_d;
    end
  end

  assign bus.alarma_pin_incorrecto  = pin_al_q;
  assign bus.alarma_bloqueo         = blk_q;
  assign bus.senal_abrir_compuerta  = abrir_q;
  assign bus.senal_cerrar_compuerta = cerrar_q;
  assign bus.lleno                  = lleno_q;
  assign bus.vehiculos              = veh_q;

endmodule

// File: tb/tb_parking_gate_ctrl_p.sv
// Directed bench for parking_gate_ctrl_p with a short timeout
// and a two-car lot.
module tb_parking_gate_ctrl_p;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_run = 0;
  int   n_bad = 0;
  int   n_open;

  always #5 clock = ~clock;

  parking_gate_ctrl_p_if #(.PIN_WIDTH(8), .CNT_W(8)) bus ();

  parking_gate_ctrl_p #(
    .PIN_WIDTH   (8),
    .PIN_CODE    (8'h3D),
    .MAX_TRIES   (3),
    .OPEN_TIMEOUT(8),
    .CAPACITY    (2),
    .CNT_W       (8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input logic [7:0] v);
    bus.pin_validation = 1'b1;
    bus.pin            = v;
    tick();
    bus.pin_validation = 1'b0;
  endtask

  // Count cycles abrir stays high, starting with it already high.
  task automatic count_open();
    n_open = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.senal_abrir_compuerta) n_open++;
      else break;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".pin_al"}, 32'(bus.alarma_pin_incorrecto), 0);
    chk({tag, ".blk"},    32'(bus.alarma_bloqueo), 0);
    chk({tag, ".abrir"},  32'(bus.senal_abrir_compuerta), 0);
    chk({tag, ".cerrar"}, 32'(bus.senal_cerrar_compuerta), 0);
    chk({tag, ".lleno"},  32'(bus.lleno), 0);
    chk({tag, ".veh"},    32'(bus.vehiculos), 0);
  endtask

  initial begin
    bus.sensor_a       = 1'b0;
    bus.sensor_b       = 1'b0;
    bus.pin_validation = 1'b0;
    bus.pin            = 8'h00;
    bus.salida         = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk_all_zero("reset");

    // normal entry
    bus.sensor_a = 1'b1;
    tick();
    chk("wait.abrir", 32'(bus.senal_abrir_compuerta), 0);
    strobe(8'h3D);
    chk("entry.abrir", 32'(bus.senal_abrir_compuerta), 1);
    bus.sensor_a = 1'b0;
    bus.sensor_b = 1'b1;
    tick();
    chk("entry.abrir0", 32'(bus.senal_abrir_compuerta), 0);
    chk("entry.cerrar", 32'(bus.senal_cerrar_compuerta), 1);
    chk("entry.veh", 32'(bus.vehiculos), 1);
    bus.sensor_b = 1'b0;
    tick();
    chk("idle.cerrar", 32'(bus.senal_cerrar_compuerta), 0);

    // retry limit then timeout
    bus.sensor_a = 1'b1;
    tick();
    strobe(8'h00);
    strobe(8'h11);
    chk("retry2.al", 32'(bus.alarma_pin_incorrecto), 0);
    strobe(8'h22);
    chk("retry3.al", 32'(bus.alarma_pin_incorrecto), 1);
    chk("retry3.abrir", 32'(bus.senal_abrir_compuerta), 0);
    strobe(8'h3D);
    chk("unlock.al", 32'(bus.alarma_pin_incorrecto), 0);
    chk("unlock.abrir", 32'(bus.senal_abrir_compuerta), 1);
    count_open();
    chk("timeout.len", 32'(n_open), 8);
    chk("timeout.cerrar", 32'(bus.senal_cerrar_compuerta), 1);
    chk("timeout.veh", 32'(bus.vehiculos), 1);
    bus.sensor_a = 1'b0;
    tick();
    chk("timeout.idle", 32'(bus.senal_cerrar_compuerta), 0);

    // block from OPEN
    bus.sensor_a = 1'b1;
    tick();
    strobe(8'h3D);
    bus.sensor_a = 1'b0;
    tick();
    bus.sensor_a = 1'b1;
    bus.sensor_b = 1'b1;
    tick();
    chk("blk.alarm", 32'(bus.alarma_bloqueo), 1);
    chk("blk.abrir", 32'(bus.senal_abrir_compuerta), 0);
    bus.sensor_a = 1'b0;
    bus.sensor_b = 1'b0;
    tick();
    chk("blk.hold", 32'(bus.alarma_bloqueo), 1);
    strobe(8'h55);
    chk("blk.badpin", 32'(bus.alarma_bloqueo), 1);
    strobe(8'h3D);
    chk("blk.ret.alarm", 32'(bus.alarma_bloqueo), 0);
    chk("blk.ret.abrir", 32'(bus.senal_abrir_compuerta), 1);
    count_open();
    chk("blk.ret.len", 32'(n_open), 8);
    chk("blk.ret.veh", 32'(bus.vehiculos), 1);
    tick();

    // capacity
    bus.sensor_a = 1'b1;
    tick();
    strobe(8'h3D);
    bus.sensor_a = 1'b0;
    bus.sensor_b = 1'b1;
    tick();
    chk("cap.veh", 32'(bus.vehiculos), 2);
    chk("cap.lleno", 32'(bus.lleno), 1);
    bus.sensor_b = 1'b0;
    tick();
    bus.sensor_a = 1'b1;
    tick();
    strobe(8'h3D);
    chk("full.noopen", 32'(bus.senal_abrir_compuerta), 0);
    bus.sensor_a = 1'b0;
    bus.salida   = 1'b1;
    tick();
    bus.salida   = 1'b0;
    chk("exit.veh", 32'(bus.vehiculos), 1);
    chk("exit.lleno", 32'(bus.lleno), 0);

    // exit coincident with passage
    bus.sensor_a = 1'b1;
    tick();
    strobe(8'h3D);
    bus.sensor_a = 1'b0;
    bus.sensor_b = 1'b1;
    bus.salida   = 1'b1;
    tick();
    bus.salida   = 1'b0;
    chk("both.veh", 32'(bus.vehiculos), 1);
    chk("both.cerrar", 32'(bus.senal_cerrar_compuerta), 1);
    bus.sensor_b = 1'b0;
    tick();

    // reset in PIN_ALARM
    bus.sensor_a = 1'b1;
    tick();
    strobe(8'h01);
    strobe(8'h02);
    strobe(8'h03);
    chk("rst.pre.al", 32'(bus.alarma_pin_incorrecto), 1);
    chk("rst.pre.veh", 32'(bus.vehiculos), 1);
    reset = 1'b1;
    tick();
    chk_all_zero("rst.mid");

    // reset beats the block rule
    bus.sensor_b = 1'b1;
    tick();
    chk("rst.blk", 32'(bus.alarma_bloqueo), 0);
    reset        = 1'b0;
    bus.sensor_a = 1'b0;
    bus.sensor_b = 1'b0;
    bus.salida   = 1'b1;
    tick();
    bus.salida   = 1'b0;
    chk("exit.at0", 32'(bus.vehiculos), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_bad);
    $finish;
  end

endmodule

// File: doc/parking_gate_ctrl_p.md
# parking_gate_ctrl_p

Parametrised parking-gate controller, the next generation of the single-entry gate FSM. It checks a configurable-width PIN with a configurable retry limit and opens the gate. An open-gate timeout closes the gate if no vehicle passes. It keeps an occupancy count with a full flag that refuses new entries, and it has a blocking state entered whenever both loop sensors are active at once. It sits between the loop sensors, the PIN keypad and the barrier actuator.

## Interface
- PIN_WIDTH, 8: width of `pin`.
- PIN_CODE, 8'b00111101: correct PIN value (PIN_WIDTH bits).
- MAX_TRIES, 3: wrong PINs that raise the PIN alarm (1..15).
- OPEN_TIMEOUT, 32: cycles the gate may stay open waiting for passage (2..2^16-1).
- CAPACITY, 100: lot capacity.
- CNT_W, 8: width of `vehiculos`. Must satisfy CAPACITY < 2^CNT_W.
- Ports:
  - `clock` in 1: single clock, all state updates on the rising edge.
  - `reset` in 1: synchronous, active-high.
  - `sensor_a` in 1: entry loop sensor, high = vehicle present.
  - `sensor_b` in 1: exit-side loop sensor, high = vehicle present.
  - `pin_validation` in 1: one-cycle strobe qualifying `pin`.
  - `pin` in PIN_WIDTH: keypad value, sampled only when `pin_validation`=1.
  - `salida` in 1: one-cycle pulse, a vehicle left the lot.
  - `alarma_pin_incorrecto` out 1: wrong-PIN alarm.
  - `alarma_bloqueo` out 1: block alarm.
  - `senal_abrir_compuerta` out 1: open command.
  - `senal_cerrar_compuerta` out 1: close command.
  - `lleno` out 1: high when `vehiculos` == CAPACITY.
  - `vehiculos` out CNT_W: current occupancy.

## Operation
- All outputs are registered.
- States:
  - IDLE
  - WAIT_PIN
  - OPEN
  - PIN_ALARM
  - CLOSING
  - BLOCKED
- Internal registers:
  - `fails`, 4-bit, saturating at MAX_TRIES.
  - `timer`, 16-bit.
  - `ret_state`, the saved return state.
- "Correct PIN" means `pin_validation`=1 and `pin`==PIN_CODE. "Wrong PIN" means `pin_validation`=1 and `pin`!=PIN_CODE.
- Block rule, highest priority, applies in every state except BLOCKED: if `sensor_a` & `sensor_b`, then:
  - `ret_state` <= current state;
  - go to BLOCKED;
  - `alarma_bloqueo`=1, `senal_abrir_compuerta`=0, `senal_cerrar_compuerta`=0;
  - `alarma_pin_incorrecto` is held.
- IDLE:
  - All four alarm/command outputs = 0.
  - If `sensor_a` & ~`sensor_b` & ~`lleno`: go to WAIT_PIN, `fails`<=0.
  - If `lleno`, stay in IDLE regardless of the sensors.
- WAIT_PIN:
  - Correct PIN: go to OPEN, `fails`<=0, `timer`<=0.
  - Wrong PIN: `fails`<=`fails`+1. If `fails`+1==MAX_TRIES, go to PIN_ALARM and set `alarma_pin_incorrecto`=1.
  - ~`sensor_a` & ~`sensor_b` without a strobe: return to IDLE (vehicle backed out).
- PIN_ALARM:
  - `alarma_pin_incorrecto`=1.
  - Correct PIN: go to OPEN, alarm <=0, `fails`<=0, `timer`<=0.
  - Wrong PINs: ignored (`fails` saturates).
  - Sensors clearing does not leave this state.
- OPEN:
  - `senal_abrir_compuerta`=1. `timer` increments every cycle.
  - `sensor_b` & ~`sensor_a`: go to CLOSING with abrir=0, cerrar=1, and occupancy +1.
  - Otherwise, if `timer`==OPEN_TIMEOUT-1: go to CLOSING with abrir=0, cerrar=1, and no increment.
- CLOSING:
  - `senal_cerrar_compuerta`=1.
  - ~`sensor_b`: go to IDLE, cerrar <=0.
- BLOCKED:
  - `alarma_bloqueo`=1, abrir=0, cerrar=0.
  - Stays here while the sensors are both high, unless a correct PIN arrives.
  - Correct PIN: go to `ret_state`, `alarma_bloqueo`<=0.
  - If `ret_state`==OPEN: `timer`<=0 and abrir is re-asserted on the same edge.
  - If `ret_state`==CLOSING: cerrar is re-asserted on the same edge.
  - `fails` is preserved across BLOCKED.
  - Wrong PINs in BLOCKED: no effect.
- Occupancy:
  - The increment comes from the OPEN→CLOSING passage. The decrement comes from the `salida` pulse.
  - Both in the same cycle: unchanged.
  - Saturates at 0 (a `salida` pulse at 0 is ignored) and at CAPACITY.
  - `lleno` is registered and updates on the same edge as `vehiculos`.
- Illegal state encoding: go to IDLE on the next edge with all commands 0.

## Timing
- Reset, checked at the edge:
  - state=IDLE;
  - `alarma_pin_incorrecto`, `alarma_bloqueo`, `senal_abrir_compuerta`, `senal_cerrar_compuerta` all 0;
  - `vehiculos`=0, `lleno`=0;
  - `fails`=0, `timer`=0, `ret_state`=IDLE.
- Reset mid-operation overrides every other condition, including the block rule.
- Latency: every output change appears on the same rising edge as the state transition that causes it, i.e. one cycle after the qualifying inputs are sampled.
- Timeout: abrir is high for exactly OPEN_TIMEOUT cycles if no passage occurs.
- The block rule beats a simultaneous correct PIN, passage, or timeout in the same cycle.
- `pin_validation` is a single-cycle strobe. A strobe held high is evaluated every cycle.

## Test plan
- Normal entry with defaults:
  - Stimulus: reset; `sensor_a`=1; PIN 0x3D with strobe; then `sensor_a`=0, `sensor_b`=1; then `sensor_b`=0.
  - Response: path IDLE→WAIT_PIN→OPEN→CLOSING→IDLE; abrir high from the edge after the strobe; `vehiculos`=1.
- Retry limit:
  - Stimulus: wrong PINs 0x00, 0x11, 0x22.
  - Response: `alarma_pin_incorrecto`=1 on the edge after the third strobe.
  - Follow-up: PIN 0x3D clears the alarm and opens the gate.
- Timeout with OPEN_TIMEOUT=8:
  - Stimulus: correct PIN, then no passage.
  - Response: abrir high for 8 cycles, then cerrar=1; `vehiculos` unchanged.
- Block from OPEN:
  - Stimulus: `sensor_a`=`sensor_b`=1.
  - Response: next edge gives `alarma_bloqueo`=1 and abrir=0.
  - Follow-up: sensors released plus correct PIN returns to OPEN with abrir=1 and the timer restarted.
- Capacity with CAPACITY=2:
  - Stimulus: two entries.
  - Response: `lleno`=1; a third `sensor_a` keeps the FSM in IDLE.
  - Follow-up: a `salida` pulse gives `vehiculos`=1 and `lleno`=0.
  - Follow-up: `salida` coincident with a passage leaves the count unchanged.
- Reset mid-operation:
  - Stimulus: assert `reset` while in PIN_ALARM with `vehiculos`=1.
  - Response: all outputs and the count are 0 on the next edge.
